// File: rtl/display_arbiter_if.sv
// Display request/value bus shared between up to three requesters and the arbiter.
// The arbiter sits on the slave side; the requesters drive the master side.
interface display_arbiter_if;
    logic [2:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [2:0]  grant;
    logic [15:0] digito;
    logic        blank;

    modport master (
        output req, val0, val1, val2,
        input  grant, digito, blank
    );

    modport slave (
        input  req, val0, val1, val2,
        output grant, digito, blank
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of a shared 4-digit display: an owner keeps it for a minimum hold
// time while others wait, and the display is blanked for a fixed gap between owners.
module display_arbiter #(
    parameter int HOLD_CYCLES  = 27_000_000,
    parameter int BLANK_CYCLES = 3000
) (
    input  logic              clk,
    input  logic              rst,
    display_arbiter_if.slave  bus
);

    localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_e;

    state_e              state_q;
    logic [2:0]          grant_q;
    logic [15:0]         digito_q;
    logic                blank_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [BLANK_W-1:0]  blank_cnt_q;
    logic [1:0]          last_owner_q;

    logic                found_d;
    logic [1:0]          win_d;
    logic [1:0]          cand_d;
    logic [15:0]         win_val_d;
    logic [15:0]         owner_val_d;
    logic                others_waiting_d;

    // Search starts just past the last owner, so the last owner is the final candidate.
    always_comb begin
        found_d = 1'b0;
        win_d   = 2'd0;
        cand_d  = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand_d = 2'((int'(last_owner_q) + k) % 3);
            if (!found_d && bus.req[cand_d]) begin
                found_d = 1'b1;
                win_d   = cand_d;
            end
        end
    end

    always_comb begin
        win_val_d = bus.val0;
        case (win_d)
            2'd1:    win_val_d = bus.val1;
            2'd2:    win_val_d = bus.val2;
            default: win_val_d = bus.val0;
        endcase
    end

    always_comb begin
        owner_val_d = bus.val0;
        case (last_owner_q)
            2'd1:    owner_val_d = bus.val1;
            2'd2:    owner_val_d = bus.val2;
            default: owner_val_d = bus.val0;
        endcase
    end

    assign others_waiting_d = |(bus.req & ~grant_q);

    // NOTE: every register in this block uses <= so all next-state terms see the
    // pre-edge values; a blocking '=' here would let later lines see updated state.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and covers every register, including counters,
        // so an abort mid-SHOW or mid-BLANK leaves nothing half-updated.
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 3'b000;
            digito_q     <= 16'h0000;
            blank_q      <= 1'b1;
            hold_q       <= '0;
            blank_cnt_q  <= '0;
            last_owner_q <= 2'd2;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q      <= SHOW;
                        grant_q      <= 3'(3'b001 << win_d);
                        digito_q     <= win_val_d;
                        blank_q      <= 1'b0;
                        last_owner_q <= win_d;
                        hold_q       <= '0;
                    end
                end

                SHOW: begin
                    digito_q <= owner_val_d;
                    // Owner release and hold expiry share one exit path into BLANK.
                    if (!bus.req[last_owner_q] ||
                        (hold_q == HOLD_LAST && others_waiting_d)) begin
                        state_q     <= BLANK;
                        grant_q     <= 3'b000;
                        blank_q     <= 1'b1;
                        blank_cnt_q <= '0;
                    end else if (hold_q != HOLD_LAST) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end

                BLANK: begin
                    if (blank_cnt_q == BLANK_LAST) begin
                        if (found_d) begin
                            state_q      <= SHOW;
                            grant_q      <= 3'(3'b001 << win_d);
                            digito_q     <= win_val_d;
                            blank_q      <= 1'b0;
                            last_owner_q <= win_d;
                            hold_q       <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        blank_cnt_q <= blank_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    grant_q <= 3'b000;
                    blank_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.grant  = grant_q;
    assign bus.digito = digito_q;
    assign bus.blank  = blank_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=4, BLANK_CYCLES=2; outputs are
// sampled on the falling edge, edge 1 being the first rising edge after rst falls.
module tb_display_arbiter;

    logic clk;
    logic rst;
    logic inv_en;
    int   n_checks;
    int   n_err;

    display_arbiter_if bus ();

    display_arbiter #(
        .HOLD_CYCLES (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [2:0] g, input logic [15:0] d,
                              input logic b);
        check({tag, ".grant"},  32'(bus.grant),  32'(g));
        check({tag, ".digito"}, 32'(bus.digito), 32'(d));
        check({tag, ".blank"},  32'(bus.blank),  32'(b));
    endtask

    task automatic apply_reset(input logic [2:0] r);
        rst     = 1'b1;
        bus.req = r;
        tick();
        inv_en = 1'b1;
        expect_out("reset", 3'b000, 16'h0000, 1'b1);
        rst = 1'b0;
    endtask

    // Invariant: grant is at most one-hot and blank mirrors an empty grant.
    always @(negedge clk) begin
        if (inv_en) begin
            check("inv_onehot", 32'($onehot0(bus.grant)), 32'd1);
            check("inv_blank",  32'(bus.blank), 32'(bus.grant == 3'b000));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        inv_en   = 1'b0;
        n_checks = 0;
        n_err    = 0;
        bus.req  = 3'b000;
        bus.val0 = 16'h1234;
        bus.val1 = 16'h2222;
        bus.val2 = 16'h3333;
        @(negedge clk);

        // Single requester: owns the display indefinitely and tracks val0 in one edge.
        apply_reset(3'b001);
        tick();
        expect_out("single.e1", 3'b001, 16'h1234, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_out("single.hold", 3'b001, 16'h1234, 1'b0);
        end
        bus.val0 = 16'hABCD;
        tick();
        expect_out("single.val", 3'b001, 16'hABCD, 1'b0);
        bus.val1 = 16'hFFFF;
        bus.val2 = 16'hEEEE;
        tick();
        expect_out("single.nonowner", 3'b001, 16'hABCD, 1'b0);
        bus.val1 = 16'h2222;
        bus.val2 = 16'h3333;

        // Rotation between requesters 0 and 1.
        bus.val0 = 16'h1111;
        apply_reset(3'b011);
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_out("rot.show0", 3'b001, 16'h1111, 1'b0);
        end
        for (int i = 5; i <= 6; i++) begin
            tick();
            expect_out("rot.blank0", 3'b000, 16'h1111, 1'b1);
        end
        for (int i = 7; i <= 10; i++) begin
            tick();
            expect_out("rot.show1", 3'b010, 16'h2222, 1'b0);
        end
        for (int i = 11; i <= 12; i++) begin
            tick();
            expect_out("rot.blank1", 3'b000, 16'h2222, 1'b1);
        end
        tick();
        expect_out("rot.back0", 3'b001, 16'h1111, 1'b0);

        // Fairness across all three requesters.
        apply_reset(3'b111);
        for (int o = 0; o < 3; o++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                expect_out("rr.show", 3'(3'b001 << o), (o == 0) ? 16'h1111 :
                           (o == 1) ? 16'h2222 : 16'h3333, 1'b0);
            end
            for (int i = 0; i < 2; i++) begin
                tick();
                expect_out("rr.blank", 3'b000, (o == 0) ? 16'h1111 :
                           (o == 1) ? 16'h2222 : 16'h3333, 1'b1);
            end
        end
        tick();
        expect_out("rr.wrap", 3'b001, 16'h1111, 1'b0);

        // Early release: owner drops after edge 2, blank at 3-4, idle at 5.
        bus.val0 = 16'h5555;
        apply_reset(3'b001);
        tick();
        expect_out("rel.e1", 3'b001, 16'h5555, 1'b0);
        tick();
        expect_out("rel.e2", 3'b001, 16'h5555, 1'b0);
        bus.req = 3'b000;
        tick();
        expect_out("rel.e3", 3'b000, 16'h5555, 1'b1);
        tick();
        expect_out("rel.e4", 3'b000, 16'h5555, 1'b1);
        tick();
        expect_out("rel.e5", 3'b000, 16'h5555, 1'b1);
        bus.val0 = 16'h6666;
        tick();
        expect_out("rel.idle", 3'b000, 16'h5555, 1'b1);

        // req changes mid-BLANK are ignored until the final BLANK cycle.
        apply_reset(3'b011);
        for (int i = 1; i <= 5; i++) tick();
        expect_out("ign.e5", 3'b000, 16'h6666, 1'b1);
        bus.req = 3'b000;
        tick();
        expect_out("ign.e6", 3'b000, 16'h6666, 1'b1);
        bus.req = 3'b100;
        tick();
        expect_out("ign.e7", 3'b100, 16'h3333, 1'b0);

        // Owner drop coincident with hold expiry takes a single BLANK entry.
        apply_reset(3'b011);
        for (int i = 1; i <= 4; i++) tick();
        expect_out("sim.e4", 3'b001, 16'h6666, 1'b0);
        bus.req = 3'b010;
        tick();
        expect_out("sim.e5", 3'b000, 16'h6666, 1'b1);
        tick();
        expect_out("sim.e6", 3'b000, 16'h6666, 1'b1);
        tick();
        expect_out("sim.e7", 3'b010, 16'h2222, 1'b0);

        // Reset during BLANK, then first arbitration favours requester 0 order.
        apply_reset(3'b011);
        for (int i = 1; i <= 5; i++) tick();
        expect_out("rmid.blank", 3'b000, 16'h6666, 1'b1);
        apply_reset(3'b110);
        tick();
        expect_out("rmid.first", 3'b010, 16'h2222, 1'b0);

        inv_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
